// File: rtl/vga_timing_if.sv
// Configuration port of the VGA raster timing generator: one valid/ready offer carrying
// a complete horizontal/vertical timing set, plus a reject pulse back to the offerer.
interface vga_timing_if #(
    parameter int unsigned CW = 12
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic          cfg_err;
    logic [CW-1:0] cfg_hact;
    logic [CW-1:0] cfg_hfp;
    logic [CW-1:0] cfg_hsyn;
    logic [CW-1:0] cfg_hbp;
    logic [CW-1:0] cfg_vact;
    logic [CW-1:0] cfg_vfp;
    logic [CW-1:0] cfg_vsyn;
    logic [CW-1:0] cfg_vbp;
    logic          cfg_hpol;
    logic          cfg_vpol;

    modport master (
        output cfg_valid, cfg_hact, cfg_hfp, cfg_hsyn, cfg_hbp,
               cfg_vact, cfg_vfp, cfg_vsyn, cfg_vbp, cfg_hpol, cfg_vpol,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_hact, cfg_hfp, cfg_hsyn, cfg_hbp,
               cfg_vact, cfg_vfp, cfg_vsyn, cfg_vbp, cfg_hpol, cfg_vpol,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Runtime-reconfigurable raster timing generator: pixel coordinates, line/frame strobes and
// LAT-delayed sync/blank outputs. New timing is staged in a pending slot and applied at frame end.
module vga_timing_gen #(
    parameter int unsigned CW     = 12,
    parameter int unsigned LAT    = 2,
    parameter int unsigned D_HACT = 640,
    parameter int unsigned D_HFP  = 16,
    parameter int unsigned D_HSYN = 96,
    parameter int unsigned D_HBP  = 48,
    parameter int unsigned D_VACT = 480,
    parameter int unsigned D_VFP  = 11,
    parameter int unsigned D_VSYN = 2,
    parameter int unsigned D_VBP  = 32,
    parameter int unsigned D_HPOL = 0,
    parameter int unsigned D_VPOL = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_pix_en,
    vga_timing_if.slave   cfg,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_line_start,
    output logic          o_frame_start,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_blank_b
);
    localparam int unsigned TW       = CW + 2;
    localparam logic        DEF_HPOL = D_HPOL[0];
    localparam logic        DEF_VPOL = D_VPOL[0];

    logic [CW-1:0] r_x, r_y;
    logic [CW-1:0] r_hact, r_hfp, r_hsyn, r_hbp, r_vact, r_vfp, r_vsyn, r_vbp;
    logic          r_hpol, r_vpol;
    logic [CW-1:0] r_p_hact, r_p_hfp, r_p_hsyn, r_p_hbp, r_p_vact, r_p_vfp, r_p_vsyn, r_p_vbp;
    logic          r_p_hpol, r_p_vpol;
    logic          r_pend, r_err;

    logic [TW-1:0] w_cfg_htot, w_cfg_vtot;
    logic          w_cfg_nz, w_cfg_ok, w_acc;
    logic [CW-1:0] w_htot_m1, w_vtot_m1, w_hs_start, w_hs_end, w_vs_start, w_vs_end;
    logic          w_x_last, w_y_last, w_apply;
    logic          w_hs_act, w_vs_act, w_act, w_hsync, w_vsync;

    // Offer validation: totals widened so an oversized set cannot wrap into range
    assign w_cfg_htot = TW'(cfg.cfg_hact) + TW'(cfg.cfg_hfp) + TW'(cfg.cfg_hsyn) + TW'(cfg.cfg_hbp);
    assign w_cfg_vtot = TW'(cfg.cfg_vact) + TW'(cfg.cfg_vfp) + TW'(cfg.cfg_vsyn) + TW'(cfg.cfg_vbp);
    assign w_cfg_nz   = (|cfg.cfg_hact) & (|cfg.cfg_hfp) & (|cfg.cfg_hsyn) & (|cfg.cfg_hbp) &
                        (|cfg.cfg_vact) & (|cfg.cfg_vfp) & (|cfg.cfg_vsyn) & (|cfg.cfg_vbp);
    assign w_cfg_ok   = w_cfg_nz & (w_cfg_htot[TW-1:CW] == '0) & (w_cfg_vtot[TW-1:CW] == '0);
    assign w_acc      = cfg.cfg_valid & ~r_pend;

    assign cfg.cfg_ready = ~r_pend;
    assign cfg.cfg_err   = r_err;

    // Active timing was validated on entry, so CW-bit sums cannot overflow
    assign w_htot_m1  = r_hact + r_hfp + r_hsyn + r_hbp - CW'(1);
    assign w_vtot_m1  = r_vact + r_vfp + r_vsyn + r_vbp - CW'(1);
    assign w_hs_start = r_hact + r_hfp;
    assign w_hs_end   = w_hs_start + r_hsyn;
    assign w_vs_start = r_vact + r_vfp;
    assign w_vs_end   = w_vs_start + r_vsyn;
    assign w_x_last   = (r_x == w_htot_m1);
    assign w_y_last   = (r_y == w_vtot_m1);
    assign w_apply    = i_pix_en & w_x_last & w_y_last & r_pend;

    assign w_hs_act = (r_x >= w_hs_start) & (r_x < w_hs_end);
    assign w_vs_act = (r_y >= w_vs_start) & (r_y < w_vs_end);
    assign w_act    = (r_x < r_hact) & (r_y < r_vact);
    assign w_hsync  = r_hpol ? w_hs_act : ~w_hs_act;
    assign w_vsync  = r_vpol ? w_vs_act : ~w_vs_act;

    // Raster counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_pix_en) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? '0 : r_y + CW'(1);
            end else begin
                r_x <= r_x + CW'(1);
            end
        end
    end

    // Pending slot capture, reject pulse and frame-boundary apply
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hact <= CW'(D_HACT); r_hfp <= CW'(D_HFP); r_hsyn <= CW'(D_HSYN); r_hbp <= CW'(D_HBP);
            r_vact <= CW'(D_VACT); r_vfp <= CW'(D_VFP); r_vsyn <= CW'(D_VSYN); r_vbp <= CW'(D_VBP);
            r_hpol <= DEF_HPOL;    r_vpol <= DEF_VPOL;
            r_p_hact <= '0; r_p_hfp <= '0; r_p_hsyn <= '0; r_p_hbp <= '0;
            r_p_vact <= '0; r_p_vfp <= '0; r_p_vsyn <= '0; r_p_vbp <= '0;
            r_p_hpol <= 1'b0; r_p_vpol <= 1'b0;
            r_pend <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_acc & ~w_cfg_ok;
            if (w_apply) begin
                r_hact <= r_p_hact; r_hfp <= r_p_hfp; r_hsyn <= r_p_hsyn; r_hbp <= r_p_hbp;
                r_vact <= r_p_vact; r_vfp <= r_p_vfp; r_vsyn <= r_p_vsyn; r_vbp <= r_p_vbp;
                r_hpol <= r_p_hpol; r_vpol <= r_p_vpol;
                r_pend <= 1'b0;
            end
            if (w_acc & w_cfg_ok) begin
                r_p_hact <= cfg.cfg_hact; r_p_hfp <= cfg.cfg_hfp;
                r_p_hsyn <= cfg.cfg_hsyn; r_p_hbp <= cfg.cfg_hbp;
                r_p_vact <= cfg.cfg_vact; r_p_vfp <= cfg.cfg_vfp;
                r_p_vsyn <= cfg.cfg_vsyn; r_p_vbp <= cfg.cfg_vbp;
                r_p_hpol <= cfg.cfg_hpol; r_p_vpol <= cfg.cfg_vpol;
                r_pend   <= 1'b1;
            end
        end
    end

    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_line_start  = i_pix_en & (r_x == '0);
    assign o_frame_start = o_line_start & (r_y == '0);

    generate
        if (LAT == 0) begin : g_nodly
            assign o_hsync   = w_hsync;
            assign o_vsync   = w_vsync;
            assign o_blank_b = w_act;
        end else begin : g_dly
            // Stages hold {hsync, vsync, act} triples, newest in the low bits
            logic [3*LAT-1:0] r_dly;
            logic [3*LAT+2:0] w_chain;
            assign w_chain = {r_dly, w_hsync, w_vsync, w_act};

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_dly <= {LAT{~DEF_HPOL, ~DEF_VPOL, 1'b0}};
                end else if (i_pix_en) begin
                    r_dly <= w_chain[3*LAT-1:0];
                end
            end

            assign o_hsync   = r_dly[3*LAT-1];
            assign o_vsync   = r_dly[3*LAT-2];
            assign o_blank_b = r_dly[3*LAT-3];
        end
    endgenerate
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: frame-index reference model with a delay queue, checked every
// cycle, plus directed scenarios pinned by hand-computed frame lengths and sync positions.
module tb_vga_timing_gen;
    localparam int unsigned CW     = 12;
    localparam int unsigned LAT    = 2;
    localparam int          D_HACT = 16, D_HFP = 4, D_HSYN = 6, D_HBP = 4;
    localparam int          D_VACT = 10, D_VFP = 2, D_VSYN = 2, D_VBP = 3;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          pix_en = 1'b0;
    logic [CW-1:0] x, y;
    logic          line_start, frame_start, hsync, vsync, blank_b;

    vga_timing_if #(.CW(CW)) ifc ();

    vga_timing_gen #(
        .CW(CW), .LAT(LAT),
        .D_HACT(D_HACT), .D_HFP(D_HFP), .D_HSYN(D_HSYN), .D_HBP(D_HBP),
        .D_VACT(D_VACT), .D_VFP(D_VFP), .D_VSYN(D_VSYN), .D_VBP(D_VBP),
        .D_HPOL(0), .D_VPOL(0)
    ) dut (
        .clk(clk), .reset(reset), .i_pix_en(pix_en), .cfg(ifc),
        .o_x(x), .o_y(y), .o_line_start(line_start), .o_frame_start(frame_start),
        .o_hsync(hsync), .o_vsync(vsync), .o_blank_b(blank_b)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit started = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference model: timing set, pending slot, and position as an index into the frame
    int         mt[8];
    bit         mhp, mvp;
    int         mp[8];
    bit         mphp, mpvp;
    bit         m_pend, m_err;
    int         m_n;
    logic [2:0] dq[$];

    function automatic int m_ht(); return mt[0] + mt[1] + mt[2] + mt[3]; endfunction
    function automatic int m_vt(); return mt[4] + mt[5] + mt[6] + mt[7]; endfunction

    function automatic logic [2:0] m_sample(input int n);
        int  px, py;
        bit  hs, vs;
        px = n % m_ht();
        py = n / m_ht();
        hs = (px >= mt[0] + mt[1]) && (px < mt[0] + mt[1] + mt[2]);
        vs = (py >= mt[4] + mt[5]) && (py < mt[4] + mt[5] + mt[6]);
        return {mhp ? hs : !hs, mvp ? vs : !vs, (px < mt[0]) && (py < mt[4])};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mt = '{D_HACT, D_HFP, D_HSYN, D_HBP, D_VACT, D_VFP, D_VSYN, D_VBP};
            mhp = 1'b0; mvp = 1'b0;
            m_pend = 1'b0; m_err = 1'b0; m_n = 0;
            dq.delete();
            for (int i = 0; i < LAT; i++) dq.push_back(3'b110);
        end else begin
            bit acc;
            int f[8];
            acc = ifc.cfg_valid && !m_pend;
            if (pix_en) begin
                dq.push_back(m_sample(m_n));
                void'(dq.pop_front());
                if (m_n == m_ht() * m_vt() - 1) begin
                    m_n = 0;
                    if (m_pend) begin
                        mt = mp; mhp = mphp; mvp = mpvp; m_pend = 1'b0;
                    end
                end else begin
                    m_n++;
                end
            end
            m_err = 1'b0;
            if (acc) begin
                f = '{int'(ifc.cfg_hact), int'(ifc.cfg_hfp), int'(ifc.cfg_hsyn), int'(ifc.cfg_hbp),
                      int'(ifc.cfg_vact), int'(ifc.cfg_vfp), int'(ifc.cfg_vsyn), int'(ifc.cfg_vbp)};
                if (f[0] > 0 && f[1] > 0 && f[2] > 0 && f[3] > 0 && f[4] > 0 && f[5] > 0 &&
                    f[6] > 0 && f[7] > 0 && f[0] + f[1] + f[2] + f[3] < 4096 &&
                    f[4] + f[5] + f[6] + f[7] < 4096) begin
                    mp = f; mphp = ifc.cfg_hpol; mpvp = ifc.cfg_vpol; m_pend = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (started) begin
            int ex, ey;
            ex = m_n % m_ht();
            ey = m_n / m_ht();
            chk("x", int'(x), ex);
            chk("y", int'(y), ey);
            chk("line_start", int'(line_start), int'(pix_en && ex == 0));
            chk("frame_start", int'(frame_start), int'(pix_en && ex == 0 && ey == 0));
            chk("hsync", int'(hsync), int'(dq[0][2]));
            chk("vsync", int'(vsync), int'(dq[0][1]));
            chk("blank_b", int'(blank_b), int'(dq[0][0]));
            chk("cfg_ready", int'(ifc.cfg_ready), int'(!m_pend));
            chk("cfg_err", int'(ifc.cfg_err), int'(m_err));
        end
    end

    task automatic set_cfg(input int ha, hf, hs, hb, va, vf, vs, vb, input bit hp, vp);
        ifc.cfg_hact = CW'(ha); ifc.cfg_hfp = CW'(hf); ifc.cfg_hsyn = CW'(hs); ifc.cfg_hbp = CW'(hb);
        ifc.cfg_vact = CW'(va); ifc.cfg_vfp = CW'(vf); ifc.cfg_vsyn = CW'(vs); ifc.cfg_vbp = CW'(vb);
        ifc.cfg_hpol = hp;      ifc.cfg_vpol = vp;
    endtask

    task automatic offer(input int ha, hf, hs, hb, va, vf, vs, vb, input bit hp, vp);
        @(posedge clk); #1;
        set_cfg(ha, hf, hs, hb, va, vf, vs, vb, hp, vp);
        ifc.cfg_valid = 1'b1;
        @(posedge clk); #1;
        ifc.cfg_valid = 1'b0;
    endtask

    // Cycles between two consecutive frame_start strobes
    task automatic frame_len(input string nm, input int exp);
        int  len;
        bit  seen;
        len  = 0;
        seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            len++;
            if (frame_start) begin
                if (seen) break;
                seen = 1'b1;
                len  = 0;
            end
        end
        chk(nm, len, exp);
    endtask

    initial begin
        int idx, low, len;
        bit seen, hp, vp, okl;
        int ha, hf, hs, hb, va, vf, vs, vb;

        ifc.cfg_valid = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        started = 1'b1;
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);
        chk("rst_blank_b", int'(blank_b), 0);
        chk("rst_ready", int'(ifc.cfg_ready), 1);
        chk("rst_err", int'(ifc.cfg_err), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        reset = 1'b0;

        // Default timing 30x17: hsync low on x=20..25, seen two enabled cycles later
        @(posedge clk); #1;
        pix_en = 1'b1;
        @(negedge clk);
        chk("first_frame_start", int'(frame_start), 1);
        idx = 0;
        okl = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!hsync) begin okl = 1'b1; break; end
            idx++;
            @(negedge clk);
        end
        chk("hsync_fall_idx", okl ? idx : -1, 22);
        low = 0;
        for (int i = 0; i < 50 && !hsync; i++) begin
            low++;
            @(negedge clk);
        end
        chk("hsync_low_width", low, 6);
        frame_len("default_frame_len", 510);

        // Alternating pix_en doubles the frame period
        len = 0;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            pix_en = ~pix_en;
            @(negedge clk);
            len++;
            if (frame_start) begin
                if (seen) break;
                seen = 1'b1;
                len = 0;
            end
        end
        chk("toggled_frame_len", len, 1020);
        @(posedge clk); #1;
        pix_en = 1'b1;

        // Mid-frame reconfiguration: 15x11, active-high syncs, applied at next boundary
        repeat (37) @(posedge clk);
        offer(8, 2, 3, 2, 6, 1, 2, 2, 1'b1, 1'b1);
        chk("cfg_ready_drop", int'(ifc.cfg_ready), 0);
        frame_len("new_frame_len", 165);

        // Rejected offers: zero field, and horizontal total overflow
        offer(8, 2, 0, 2, 6, 1, 2, 2, 1'b0, 1'b0);
        chk("err_zero_pulse", int'(ifc.cfg_err), 1);
        chk("err_zero_ready", int'(ifc.cfg_ready), 1);
        @(posedge clk); #1;
        chk("err_zero_clear", int'(ifc.cfg_err), 0);
        offer(4095, 2, 3, 2, 6, 1, 2, 2, 1'b0, 1'b0);
        chk("err_ovf_pulse", int'(ifc.cfg_err), 1);
        chk("err_ovf_ready", int'(ifc.cfg_ready), 1);
        frame_len("timing_unchanged_len", 165);

        // Accept on the apply cycle itself: takes effect one frame later
        okl = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (m_n == m_ht() * m_vt() - 1) begin okl = 1'b1; break; end
        end
        chk("reach_apply_cycle", int'(okl), 1);
        set_cfg(10, 3, 4, 3, 8, 2, 3, 2, 1'b0, 1'b1);
        ifc.cfg_valid = 1'b1;
        @(posedge clk); #1;
        ifc.cfg_valid = 1'b0;
        chk("late_accept_ready", int'(ifc.cfg_ready), 0);
        frame_len("late_old_len", 165);
        frame_len("late_new_len", 300);

        // Reset with a pending config mid-frame
        offer(8, 2, 3, 2, 6, 1, 2, 2, 1'b1, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        pix_en = 1'b0;
        #1;
        chk("mid_rst_x", int'(x), 0);
        chk("mid_rst_y", int'(y), 0);
        chk("mid_rst_ready", int'(ifc.cfg_ready), 1);
        chk("mid_rst_blank_b", int'(blank_b), 0);
        chk("mid_rst_hsync", int'(hsync), 1);
        chk("mid_rst_vsync", int'(vsync), 1);
        @(posedge clk); #1;
        reset = 1'b0;
        pix_en = 1'b1;
        frame_len("post_rst_len", 510);
        frame_len("pending_dropped_len", 510);

        // Randomized pix_en and config offers, some deliberately invalid
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk); #1;
            pix_en = ($urandom_range(0, 3) != 0);
            ifc.cfg_valid = ($urandom_range(0, 29) == 0);
            if (ifc.cfg_valid) begin
                ha = $urandom_range(1, 12); hf = $urandom_range(1, 4);
                hs = $urandom_range(1, 4);  hb = $urandom_range(1, 4);
                va = $urandom_range(1, 8);  vf = $urandom_range(1, 4);
                vs = $urandom_range(1, 4);  vb = $urandom_range(1, 4);
                hp = 1'($urandom_range(0, 1));
                vp = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       ha = 0;
                        1:       vs = 0;
                        2:       ha = 4095;
                        default: va = 4090;
                    endcase
                end
                set_cfg(ha, hf, hs, hb, va, vf, vs, vb, hp, vp);
            end
        end
        @(posedge clk); #1;
        ifc.cfg_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
